// File: rtl/result_text_gen.sv
// Result-line text generator: converts a signed 16-bit result (or NaN) to six
// glyph indices, then scans the 48x16 text box and turns glyph ROM rows into pixels.

module result_text_gen_dab (
  input  logic [3:0] i_nib,
  output logic [3:0] o_nib
);
  assign o_nib = (i_nib >= 4'd5) ? i_nib + 4'd3 : i_nib;
endmodule

module result_text_gen #(
  parameter int          X_ORIGIN = 256,
  parameter int          Y_ORIGIN = 224,
  parameter logic [11:0] FG_RGB   = 12'hFFF,
  parameter logic [11:0] BG_RGB   = 12'h000
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_video_on,
  input  logic [9:0]  i_x,
  input  logic [9:0]  i_y,
  input  logic [15:0] i_value,
  input  logic        i_value_valid,
  input  logic        i_nan,
  output logic        o_busy,
  output logic [10:0] o_rom_addr,
  input  logic [7:0]  i_rom_data,
  output logic [11:0] o_rgb
);

  localparam int NUM_DIG = 5;
  localparam int NUM_SLOT = 6;
  localparam logic [3:0] G_BLANK = 4'hF;
  localparam logic [3:0] G_MINUS = 4'hA;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_FORMAT} state_t;

  state_t r_state, w_next;

  logic [15:0]                     r_mag;
  logic [4*NUM_DIG-1:0]            r_bcd;
  logic [4*NUM_DIG-1:0]            w_adj;
  logic [3:0]                      r_cnt;
  logic                            r_neg;
  logic                            r_nan;
  logic [NUM_SLOT-1:0][3:0]        r_buf;
  logic [NUM_SLOT-1:0][3:0]        w_fmt;
  logic [2:0]                      w_msd;

  // ---------------- conversion FSM ----------------
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) r_state <= S_IDLE;
    else            r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (i_value_valid) w_next = i_nan ? S_FORMAT : S_SHIFT;
      S_SHIFT:  if (r_cnt == 4'd15) w_next = S_FORMAT;
      S_FORMAT: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  assign o_busy = (r_state != S_IDLE);

  genvar g;
  generate
    for (g = 0; g < NUM_DIG; g++) begin : g_dab
      result_text_gen_dab u_dab (
        .i_nib (r_bcd[4*g +: 4]),
        .o_nib (w_adj[4*g +: 4])
      );
    end
  endgenerate

  // Digit i (0 = ones) lands in slot 5-i; the minus sign sits just left of the MSD.
  always_comb begin
    w_msd = 3'd0;
    for (int i = 1; i < NUM_DIG; i++)
      if (r_bcd[4*i +: 4] != 4'h0) w_msd = 3'(i);
    w_fmt[0] = G_BLANK;
    for (int s = 1; s < NUM_SLOT; s++)
      w_fmt[s] = (3'(5 - s) <= w_msd) ? r_bcd[4*(5-s) +: 4] : G_BLANK;
    if (r_neg)
      for (int s = 0; s < NUM_SLOT - 1; s++)
        if (3'(s) == 3'd4 - w_msd) w_fmt[s] = G_MINUS;
    if (r_nan) w_fmt = {4'hC, 4'hB, 4'hC, G_BLANK, G_BLANK, G_BLANK};
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_mag <= '0;
      r_bcd <= '0;
      r_cnt <= '0;
      r_neg <= 1'b0;
      r_nan <= 1'b0;
      for (int s = 0; s < NUM_SLOT; s++)
        r_buf[s] <= (s == NUM_SLOT - 1) ? 4'h0 : G_BLANK;
    end else begin
      case (r_state)
        S_IDLE: if (i_value_valid) begin
          r_neg <= i_value[15];
          r_nan <= i_nan;
          r_mag <= i_value[15] ? (16'd0 - i_value) : i_value;
          r_bcd <= '0;
          r_cnt <= '0;
        end
        S_SHIFT: begin
          r_bcd <= {w_adj[4*NUM_DIG-2:0], r_mag[15]};
          r_mag <= {r_mag[14:0], 1'b0};
          r_cnt <= r_cnt + 4'd1;
        end
        S_FORMAT: r_buf <= w_fmt;
        default: ;
      endcase
    end
  end

  // ---------------- render pipeline ----------------
  logic [9:0]  w_dx, w_dy;
  logic        w_in_box, w_blank;
  logic [2:0]  w_slot;
  logic [3:0]  w_row, w_glyph;
  logic [2:0]  r_dx_q;
  logic        r_in_box_q, r_blank_q, r_vid_q;
  logic        w_lit;
  logic [11:0] r_rgb;

  assign w_dx     = i_x - 10'(X_ORIGIN);
  assign w_dy     = i_y - 10'(Y_ORIGIN);
  assign w_in_box = (w_dx < 10'd48) && (w_dy < 10'd16);
  assign w_slot   = w_dx[5:3];
  assign w_row    = w_dy[3:0];

  always_comb begin
    w_glyph = G_BLANK;
    if (w_in_box)
      for (int s = 0; s < NUM_SLOT; s++)
        if (w_slot == 3'(s)) w_glyph = r_buf[s];
  end

  assign w_blank    = (w_glyph == G_BLANK);
  // Blank cells point at a known-populated ROM word instead of an empty region.
  assign o_rom_addr = w_blank ? 11'h300 : {3'b011, w_glyph, w_row};

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_dx_q     <= '0;
      r_in_box_q <= 1'b0;
      r_blank_q  <= 1'b1;
      r_vid_q    <= 1'b0;
    end else begin
      r_dx_q     <= w_dx[2:0];
      r_in_box_q <= w_in_box;
      r_blank_q  <= w_blank;
      r_vid_q    <= i_video_on;
    end
  end

  assign w_lit = i_rom_data[3'd7 - r_dx_q] && r_in_box_q && !r_blank_q;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) r_rgb <= 12'h000;
    else            r_rgb <= !r_vid_q ? 12'h000 : (w_lit ? FG_RGB : BG_RGB);
  end

  assign o_rgb = r_rgb;

endmodule
